// File: rtl/y86_seq_ctrl.sv
// Y86 SEQ multi-cycle sequencer: walks each instruction through its stages,
// owns the PC, the status code and the retire/cycle counters.
module y86_seq_ctrl #(
  parameter int ADDR_W     = 64,
  parameter int IMEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic [ADDR_W-1:0] nextPC,
  input  logic              imem_error,
  input  logic              instr_valid,
  input  logic              hlt,
  input  logic              mem_ready,
  input  logic              dmem_error,
  output logic [ADDR_W-1:0] PC,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              pc_en,
  output logic [2:0]        stat,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_PCUPD,
    S_STOP
  } state_t;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  localparam logic [ADDR_W-1:0] IMEM_LIM =
    ADDR_W'(IMEM_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic [CNT_W-1:0]  ccnt_q, ccnt_d;
  logic              retire;
  logic              run;

  assign run = (state_q != S_IDLE) &&
               (state_q != S_STOP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if ((pc_q >= IMEM_LIM) || imem_error) begin
          state_d = S_STOP;
          stat_d  = ST_ADR;
        end else if (!instr_valid) begin
          state_d = S_STOP;
          stat_d  = ST_INS;
        end else if (hlt) begin
          state_d = S_STOP;
          stat_d  = ST_HLT;
          retire  = 1'b1;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_MEM;
      S_MEM: begin
        if (mem_ready) begin
          if (dmem_error) begin
            state_d = S_STOP;
            stat_d  = ST_ADR;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d    = nextPC;
        retire  = 1'b1;
        state_d = step_mode ? S_IDLE : S_FETCH;
      end
      S_STOP: state_d = S_STOP;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    icnt_d = icnt_q;
    ccnt_d = ccnt_q;
    if (retire && (icnt_q != '1))
      icnt_d = icnt_q + CNT_W'(1);
    if (run && (ccnt_q != '1))
      ccnt_d = ccnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= ST_AOK;
      icnt_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      icnt_q  <= icnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign PC          = pc_q;
  assign stat        = stat_q;
  assign running     = run;
  assign done        = (state_q == S_STOP);
  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;
  assign fetch_en    = (state_q == S_FETCH);
  assign decode_en   = (state_q == S_DECODE);
  assign exec_en     = (state_q == S_EXEC);
  assign mem_en      = (state_q == S_MEM);
  assign wb_en       = (state_q == S_WB);
  assign pc_en       = (state_q == S_PCUPD);

endmodule
